pe: RTL and testbench

Processing element (PE) tile of the systolic-array NPU. Each cycle it forwards its A (row) and B (column) operands to its east/south neighbours through one register stage. When the input is valid, it multiplies the operands as signed values and adds the product into a wide local accumulator. It presents the accumulated value through a registered ReLU with saturation as `result`.

---
 rtl/npu_pkg.sv | 33 +++
 rtl/pe.sv | 119 +++++++++++
 tb/tb_pe.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// -----------------------------------------------------------------------------
// npu_pkg
// Shared definitions for the systolic-array NPU.
//   NPU_DATA_WIDTH : default operand / result width (two's-complement).
//   NPU_ACC_WIDTH  : default accumulator width; 8 guard bits above a full
//                    product so long dot products do not wrap in practice.
//   relu_sat()     : ReLU followed by saturation to the largest positive
//                    DATA_WIDTH value. Also used by array-level
//                    post-processing, so it works on the default widths.
// -----------------------------------------------------------------------------
package npu_pkg;

    localparam int NPU_DATA_WIDTH = 16;
    localparam int NPU_ACC_WIDTH  = 2 * NPU_DATA_WIDTH + 8;

    // Negative values clamp to zero. Positive values with any bit set at or
    // above the DATA_WIDTH sign position exceed the largest positive result,
    // so they clamp to 2^(DATA_WIDTH-1)-1.
    function automatic logic [NPU_DATA_WIDTH-1:0] relu_sat(
        input logic signed [NPU_ACC_WIDTH-1:0] acc
    );
        logic [NPU_DATA_WIDTH-1:0] act;
        if (acc[NPU_ACC_WIDTH-1]) begin
            act = {NPU_DATA_WIDTH{1'b0}};
        end else if (|acc[NPU_ACC_WIDTH-2:NPU_DATA_WIDTH-1]) begin
            act = {1'b0, {(NPU_DATA_WIDTH-1){1'b1}}};
        end else begin
            act = acc[NPU_DATA_WIDTH-1:0];
        end
        return act;
    endfunction

endpackage

// File: rtl/pe.sv
// -----------------------------------------------------------------------------
// pe
// Processing element of the systolic array. Forwards the A/B operands and
// their valid flag east/south through one register stage, accumulates the
// signed product of valid operand pairs into a wide wrapping accumulator and
// presents the accumulator through a registered ReLU + saturation stage.
//
// Ports
//   clk       in  1   rising-edge clock
//   rst       in  1   asynchronous active-low reset
//   a_in      in  DW  signed A operand from the west neighbour
//   b_in      in  DW  signed B operand from the north neighbour
//   valid_in  in  1   qualifies a_in/b_in for accumulation
//   a_out     out DW  a_in delayed one cycle (to east)
//   b_out     out DW  b_in delayed one cycle (to south)
//   result    out DW  ReLU/saturated accumulator, registered
//   valid_out out 1   valid_in delayed one cycle (not aligned with result)
//
// The accumulator is cleared only by reset; a new tile computation needs a
// reset pulse.
// -----------------------------------------------------------------------------
module pe
    import npu_pkg::*;
#(
    parameter int DATA_WIDTH = NPU_DATA_WIDTH,
    parameter int ACC_WIDTH  = NPU_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  valid_out
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    logic signed [PROD_WIDTH-1:0] w_a_ext;
    logic signed [PROD_WIDTH-1:0] w_b_ext;
    logic signed [PROD_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]  w_prod_ext;
    logic        [DATA_WIDTH-1:0] w_act;

    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic        [DATA_WIDTH-1:0] r_a;
    logic        [DATA_WIDTH-1:0] r_b;
    logic                         r_valid;
    logic        [DATA_WIDTH-1:0] r_result;

    // Operands are widened to the full product width before multiplying so
    // the product is exact and the multiply is purely self-sized.
    assign w_a_ext    = {{DATA_WIDTH{a_in[DATA_WIDTH-1]}}, a_in};
    assign w_b_ext    = {{DATA_WIDTH{b_in[DATA_WIDTH-1]}}, b_in};
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = ACC_WIDTH'(w_prod);

    // With the default widths the shared package helper is reused; any other
    // width pair gets an equivalent width-generic implementation.
    generate
        if ((DATA_WIDTH == NPU_DATA_WIDTH) && (ACC_WIDTH == NPU_ACC_WIDTH)) begin : g_act_pkg
            assign w_act = relu_sat(r_acc);
        end else begin : g_act_generic
            // ReLU then clamp to the largest positive DATA_WIDTH value.
            always_comb begin
                w_act = {DATA_WIDTH{1'b0}};
                if (r_acc[ACC_WIDTH-1]) begin
                    w_act = {DATA_WIDTH{1'b0}};
                end else if (|r_acc[ACC_WIDTH-2:DATA_WIDTH-1]) begin
                    w_act = {1'b0, {(DATA_WIDTH-1){1'b1}}};
                end else begin
                    w_act = r_acc[DATA_WIDTH-1:0];
                end
            end
        end
    endgenerate

    // Operand/valid forwarding: unconditional one-cycle delay.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a     <= {DATA_WIDTH{1'b0}};
            r_b     <= {DATA_WIDTH{1'b0}};
            r_valid <= 1'b0;
        end else begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_valid <= valid_in;
        end
    end

    // Accumulator: adds the product on valid cycles, wraps on overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= {ACC_WIDTH{1'b0}};
        end else if (valid_in) begin
            r_acc <= r_acc + w_prod_ext;
        end else begin
            r_acc <= r_acc;
        end
    end

    // Result register: samples the activation of the current accumulator
    // every cycle, giving two cycles from operand sample to result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result <= {DATA_WIDTH{1'b0}};
        end else begin
            r_result <= w_act;
        end
    end

    assign a_out     = r_a;
    assign b_out     = r_b;
    assign valid_out = r_valid;
    assign result    = r_result;

endmodule

// File: tb/tb_pe.sv
module tb_pe;
    import npu_pkg::*;

    localparam int DW = NPU_DATA_WIDTH;
    localparam int AW = NPU_ACC_WIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] a_in;
    logic [DW-1:0] b_in;
    logic          valid_in;
    logic [DW-1:0] a_out;
    logic [DW-1:0] b_out;
    logic [DW-1:0] result;
    logic          valid_out;

    always #5 clk = ~clk;

    pe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_in      (a_in),
        .b_in      (b_in),
        .valid_in  (valid_in),
        .a_out     (a_out),
        .b_out     (b_out),
        .result    (result),
        .valid_out (valid_out)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (plain arithmetic)
    longint m_acc;
    longint m_res;
    longint m_a;
    longint m_b;
    longint m_v;

    function automatic longint wrap_acc(input longint x);
        longint m;
        longint y;
        m = longint'(1) << AW;
        y = x % m;
        if (y >= m / 2) y = y - m;
        else if (y < -(m / 2)) y = y + m;
        return y;
    endfunction

    function automatic longint relu_model(input longint x);
        longint mx;
        mx = (longint'(1) << (DW - 1)) - 1;
        if (x < 0) return 0;
        if (x > mx) return mx;
        return x;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_a_out"},     longint'($signed(a_out)),  m_a);
        chk({tag, "_b_out"},     longint'($signed(b_out)),  m_b);
        chk({tag, "_valid_out"}, longint'(valid_out),       m_v);
        chk({tag, "_result"},    longint'($signed(result)), m_res);
    endtask

    task automatic model_reset();
        m_acc = 0; m_res = 0; m_a = 0; m_b = 0; m_v = 0;
    endtask

    // Drive one operand set, advance one edge, update model, check outputs.
    task automatic cycle(input int a, input int b, input bit v, input string tag);
        a_in     = DW'(a);
        b_in     = DW'(b);
        valid_in = v;
        @(posedge clk);
        m_res = relu_model(m_acc);
        if (v) m_acc = wrap_acc(m_acc + longint'(a) * longint'(b));
        m_a = a; m_b = b; m_v = v;
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        check_all("rst");
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        bit rst_first;
        int a;
        int b;
        bit v;
        int exp_res;
    } vec_t;

    vec_t tbl[12];

    initial begin
        rst = 1'b0; a_in = '0; b_in = '0; valid_in = 1'b0;
        model_reset();

        // Reset held with toggling inputs: outputs stay 0.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_in     = DW'($urandom_range(65535));
            b_in     = DW'($urandom_range(65535));
            valid_in = 1'b1;
            #1;
            check_all("in_reset");
        end
        @(negedge clk);
        rst = 1'b1;
        cycle(7, 9, 1'b1, "first_capture");
        cycle(0, 0, 1'b0, "first_capture2");
        chk("first_capture_result", longint'($signed(result)), 63);

        // Directed table: basic MAC, ReLU, saturation.
        tbl[0]  = '{1'b1,   10,   3, 1'b1,     0};
        tbl[1]  = '{1'b0,   -5,   4, 1'b1,    30};
        tbl[2]  = '{1'b0,  111, 222, 1'b0,    10};
        tbl[3]  = '{1'b0,    0,   0, 1'b0,    10};
        tbl[4]  = '{1'b1,   -7,   5, 1'b1,     0};
        tbl[5]  = '{1'b0,    0,   0, 1'b0,     0};
        tbl[6]  = '{1'b0,    4,  10, 1'b1,     0};
        tbl[7]  = '{1'b0,    0,   0, 1'b0,     5};
        tbl[8]  = '{1'b1,  300, 300, 1'b1,     0};
        tbl[9]  = '{1'b0,    0,   0, 1'b0, 32767};
        tbl[10] = '{1'b0, -300, 300, 1'b1, 32767};
        tbl[11] = '{1'b0,    0,   0, 1'b0,     0};
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].rst_first) do_reset();
            cycle(tbl[i].a, tbl[i].b, tbl[i].v, "tbl");
            chk($sformatf("tbl%0d_result", i), longint'($signed(result)), longint'(tbl[i].exp_res));
        end

        // Mid-operation asynchronous reset.
        do_reset();
        cycle(10, 3, 1'b1, "mid_acc");
        cycle(0, 0, 1'b0, "mid_acc2");
        chk("mid_before_rst", longint'($signed(result)), 30);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("mid_async_rst");
        @(negedge clk);
        rst = 1'b1;
        cycle(2, 2, 1'b1, "mid_after");
        cycle(0, 0, 1'b0, "mid_after2");
        chk("mid_after_result", longint'($signed(result)), 4);

        // Accumulator wrap: 512 * 2^30 = 2^39 wraps negative.
        do_reset();
        for (int i = 0; i < 514; i++) begin
            cycle(-32768, -32768, 1'b1, "wrap");
            if (i == 511) chk("wrap_pre_result", longint'($signed(result)), 32767);
            if (i == 512) chk("wrap_post_result", longint'($signed(result)), 0);
        end

        // Randomized stream with idle cycles, mixing small and full-range operands.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            int ra;
            int rb;
            if ((i / 50) % 2 == 0) begin
                ra = int'($urandom_range(40)) - 20;
                rb = int'($urandom_range(40)) - 20;
            end else begin
                ra = int'($urandom_range(65535)) - 32768;
                rb = int'($urandom_range(65535)) - 32768;
            end
            cycle(ra, rb, 1'($urandom_range(1)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
